// File: rtl/adc_trigger.sv
// Decimating level/slope trigger with hysteresis for the ADC capture path.
// Emits FRAME_LEN trigger-aligned decimated samples per frame with SOF/EOF strobes.
module adc_trigger #(
  parameter int DN        = 10,
  parameter int FRAME_LEN = 800,
  parameter int HYST      = 8,
  parameter int TIMEOUT   = 1000000
) (
  input  logic          clkADC,
  input  logic          n_reset,
  input  logic [DN-1:0] in_data,
  input  logic [DN-1:0] level,
  input  logic          slope,
  input  logic [1:0]    mode,
  input  logic [7:0]    decim,
  input  logic          rearm,
  output logic [DN-1:0] out_data,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_eof,
  output logic          armed,
  output logic          busy
);

  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0]   S_LAST = 16'(FRAME_LEN - 1);
  localparam logic [DN:0]   HYST_X = (DN + 1)'(HYST);
  localparam logic [DN:0]   MAX_X  = {1'b0, {DN{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_dcnt;
  logic          r_stb1;
  logic [DN-1:0] r_samp;
  logic          r_flag;
  logic [TW-1:0] r_tcnt;
  logic [15:0]   r_scnt;
  logic          w_stb, w_arm_hit, w_fire, w_last, w_enter_wait;

  // Hysteresis thresholds saturate at the code range ends.
  function automatic logic f_arm(input logic [DN-1:0] s, input logic [DN-1:0] lv,
                                 input logic sl);
    logic [DN:0] hi_x;
    hi_x = {1'b0, lv} + HYST_X;
    if (!sl) begin
      if ({1'b0, lv} < HYST_X) f_arm = (s == '0);
      else                     f_arm = ({1'b0, s} < ({1'b0, lv} - HYST_X));
    end else begin
      if (hi_x > MAX_X) f_arm = (s == '1);
      else              f_arm = ({1'b0, s} > hi_x);
    end
  endfunction

  function automatic logic f_cross(input logic [DN-1:0] s, input logic [DN-1:0] lv,
                                   input logic sl);
    f_cross = sl ? (s <= lv) : (s >= lv);
  endfunction

  assign w_stb        = (r_dcnt == decim);
  assign w_arm_hit    = f_arm(r_samp, level, slope);
  assign w_fire       = (r_flag && f_cross(r_samp, level, slope)) ||
                        ((mode == 2'd1) && (r_tcnt >= T_LAST));
  assign w_last       = (r_scnt == S_LAST);
  assign w_enter_wait = (w_next == S_WAIT) && (r_state != S_WAIT);
  assign armed        = (r_state == S_WAIT);
  assign busy         = (r_state == S_CAPTURE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (mode != 2'd3) w_next = S_WAIT;
      S_WAIT: begin
        if (mode == 2'd3)           w_next = S_IDLE;
        else if (r_stb1 && w_fire)  w_next = S_CAPTURE;
      end
      S_CAPTURE: if (r_stb1 && w_last) w_next = S_DONE;
      S_DONE: begin
        if (mode == 2'd3)      w_next = S_IDLE;
        else if (mode == 2'd2) begin
          if (rearm) w_next = S_WAIT;
        end else               w_next = S_WAIT;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Stage 1: decimation strobe captures the raw sample.
  always_ff @(posedge clkADC) begin
    if (w_stb) r_samp <= in_data;
  end

  // Stage 2: trigger decision and frame output registers.
  always_ff @(posedge clkADC or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= S_IDLE;
      r_dcnt    <= '0;
      r_stb1    <= 1'b0;
      r_flag    <= 1'b0;
      r_tcnt    <= '0;
      r_scnt    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_dcnt    <= (r_dcnt >= decim) ? 8'd0 : r_dcnt + 8'd1;
      r_stb1    <= w_stb;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      if (w_enter_wait) begin
        r_flag <= 1'b0;
        r_tcnt <= '0;
      end else if (r_state == S_WAIT) begin
        if (mode == 2'd1 && r_tcnt < T_LAST) r_tcnt <= r_tcnt + 1'b1;
        if (r_stb1 && w_arm_hit)             r_flag <= 1'b1;
      end
      if (r_state == S_WAIT && w_next == S_CAPTURE) begin
        out_valid <= 1'b1;
        out_sof   <= 1'b1;
        out_data  <= r_samp;
        r_scnt    <= 16'd1;
      end else if (r_state == S_CAPTURE && r_stb1) begin
        out_valid <= 1'b1;
        out_eof   <= w_last;
        out_data  <= r_samp;
        r_scnt    <= r_scnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_trigger.sv
// Directed bench for adc_trigger: table of ramp trigger scenarios plus
// hand-written auto, single-shot, hysteresis, stop and mid-frame reset sequences.
module tb_adc_trigger;

  localparam int FL = 16;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [9:0] in_data, level, out_data;
  logic       slope, rearm, out_valid, out_sof, out_eof, armed, busy;
  logic [1:0] mode;
  logic [7:0] decim;

  int checks = 0;
  int failures = 0;
  int cyc, last_edge, vcnt;
  int cval;
  logic [1:0] gmode;

  typedef struct packed {
    logic [7:0] decim;
    logic [9:0] level;
    logic       slope;
    logic [1:0] gen;
    int         exp_edge;
    int         d0;
    int         step;
  } vec_t;
  vec_t tbl [6];

  adc_trigger #(.DN(10), .FRAME_LEN(FL), .HYST(8), .TIMEOUT(50)) dut (
    .clkADC(clk), .n_reset(n_reset), .in_data(in_data), .level(level),
    .slope(slope), .mode(mode), .decim(decim), .rearm(rearm),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
    .out_eof(out_eof), .armed(armed), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [9:0] gen_val(input int c);
    case (gmode)
      2'd0:    return 10'(c % 1024);
      2'd1:    return 10'(1023 - (c % 1024));
      default: return cval[9:0];
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Outputs seen after tick() reflect rising edge number last_edge.
  task automatic tick();
    @(negedge clk);
    last_edge = cyc;
    cyc++;
    in_data = gen_val(cyc);
  endtask

  task automatic do_reset(input logic [1:0] g, input logic [1:0] m, input logic [7:0] d,
                          input logic [9:0] lv, input logic sl);
    @(negedge clk);
    n_reset = 1'b0;
    gmode = g; mode = m; decim = d; level = lv; slope = sl; rearm = 1'b0;
    cyc = 0;
    in_data = gen_val(0);
    repeat (3) @(negedge clk);
    chk("rst_outputs", {out_data, out_valid, out_sof, out_eof, armed, busy}, 0);
    n_reset = 1'b1;
  endtask

  task automatic capture_frame(input int exp_edge, input int d0, input int step,
                               input int gap, input int budget, input int rearm_i);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin tick(); n++; end
    chk("sof_seen", out_valid, 1);
    if (!out_valid) return;
    chk("sof_flag", out_sof, 1);
    chk("sof_no_eof", out_eof, 0);
    chk("sof_edge", last_edge, exp_edge);
    chk("sof_data", out_data, d0);
    chk("busy_in_frame", busy, 1);
    for (int i = 1; i < FL; i++) begin
      if (i == rearm_i) rearm = 1'b1;
      n = 0;
      do begin tick(); rearm = 1'b0; n++; end while (!out_valid && n < gap + 2);
      chk("sample_gap", n, gap);
      chk("sample_data", out_data, (d0 + i * step) & 1023);
      chk("sample_sof", out_sof, 0);
      chk("sample_eof", out_eof, (i == FL - 1) ? 1 : 0);
    end
  endtask

  task automatic hold(input int v, input int n);
    cval = v;
    repeat (n) begin tick(); if (out_valid) vcnt++; end
  endtask

  initial begin
    int n;
    n_reset = 1'b0; in_data = '0; level = '0; slope = 1'b0;
    mode = 2'd0; decim = '0; rearm = 1'b0; cval = 0; gmode = 2'd0;
    cyc = 0; last_edge = 0; vcnt = 0;

    tbl[0] = '{8'd0, 10'd512,  1'b0, 2'd0, 513, 512,  1};
    tbl[1] = '{8'd3, 10'd512,  1'b0, 2'd0, 516, 515,  4};
    tbl[2] = '{8'd0, 10'd300,  1'b1, 2'd1, 724, 300, -1};
    tbl[3] = '{8'd0, 10'd3,    1'b0, 2'd0, 4,   3,    1};
    tbl[4] = '{8'd0, 10'd1020, 1'b1, 2'd1, 4,   1020, -1};
    tbl[5] = '{8'd1, 10'd512,  1'b0, 2'd0, 514, 513,  2};

    for (int i = 0; i < 6; i++) begin
      do_reset(tbl[i].gen, 2'd0, tbl[i].decim, tbl[i].level, tbl[i].slope);
      capture_frame(tbl[i].exp_edge, tbl[i].d0, tbl[i].step,
                    int'(tbl[i].decim) + 1, 1100, -1);
    end

    // Stop mode holds IDLE; leaving it arms on the next edge.
    do_reset(2'd0, 2'd3, 8'd0, 10'd512, 1'b0);
    vcnt = 0;
    repeat (10) begin tick(); if (out_valid) vcnt++; end
    chk("stop_armed", armed, 0);
    chk("stop_valids", vcnt, 0);
    mode = 2'd0;
    tick();
    chk("stop_exit_armed", armed, 1);

    // Noise above level or inside the hysteresis band must not trigger.
    cval = 600;
    do_reset(2'd2, 2'd0, 8'd0, 10'd512, 1'b0);
    vcnt = 0;
    hold(600, 20); hold(508, 6); hold(520, 6); hold(506, 6); hold(530, 6);
    chk("hyst_no_trig", vcnt, 0);
    hold(500, 3);
    cval = 515;
    n = 0;
    while (!out_valid && n < 6) begin tick(); n++; end
    chk("hyst_trig_sof", out_sof, 1);
    chk("hyst_trig_data", out_data, 515);

    // Auto mode forces a trigger on a flat input after the timeout.
    cval = 100;
    do_reset(2'd2, 2'd1, 8'd0, 10'd512, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("auto_sof", out_sof, 1);
    chk("auto_data", out_data, 100);
    chk("auto_edge_window", (last_edge >= 40 && last_edge <= 53) ? 1 : 0, 1);

    // Single-shot: rearm during capture is ignored; DONE waits for rearm.
    do_reset(2'd0, 2'd2, 8'd0, 10'd512, 1'b0);
    capture_frame(513, 512, 1, 1, 1100, 5);
    repeat (3) tick();
    chk("single_done_armed", armed, 0);
    chk("single_done_busy", busy, 0);
    vcnt = 0;
    repeat (600) begin tick(); if (out_valid) vcnt++; end
    chk("single_no_valid", vcnt, 0);
    chk("single_still_idle", armed, 0);
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    chk("single_rearmed", armed, 1);
    capture_frame(1537, 512, 1, 1, 600, -1);

    // Reset mid-frame clears outputs at once and restarts from IDLE.
    do_reset(2'd0, 2'd0, 8'd0, 10'd512, 1'b0);
    n = 0;
    while (!out_sof && n < 1100) begin tick(); n++; end
    chk("rstmid_sof", out_sof, 1);
    vcnt = 0;
    n = 0;
    while (vcnt < 5 && n < 20) begin tick(); n++; if (out_valid) vcnt++; end
    chk("rstmid_sample5", out_data, 517);
    n_reset = 1'b0;
    #1;
    chk("rstmid_outputs", {out_data, out_valid, out_sof, out_eof, armed, busy}, 0);
    repeat (2) @(negedge clk);
    cyc = 0;
    in_data = gen_val(0);
    n_reset = 1'b1;
    tick();
    chk("rstmid_armed", armed, 1);
    capture_frame(513, 512, 1, 1, 1100, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_trigger.md
Name: adc_trigger

Overview:
- Sits between the `adc` sampler and `display_samples`, in the ADC clock domain.
- Decimates the raw ADC stream by a programmable ratio and detects a level/slope trigger with hysteresis.
- Emits one frame of FRAME_LEN decimated samples per trigger, marked with start- and end-of-frame strobes, so the display writer stores trigger-aligned waveforms.
- Supports normal, auto (timeout-forced) and single-shot modes.

Parameters:
- DN, 10, sample width in bits.
- FRAME_LEN, 800, samples per frame (2..65535).
- HYST, 8, hysteresis in LSBs used for trigger arming.
- TIMEOUT, 1000000, auto-mode forced-trigger timeout in clkADC cycles.

Ports:
- clkADC  input  1  ADC sample clock, rising edge.
- n_reset  input  1  asynchronous active-low reset.
- in_data  input  DN  raw ADC sample, valid every cycle.
- level  input  DN  trigger threshold.
- slope  input  1  0 = rising, 1 = falling.
- mode  input  2  0 normal, 1 auto, 2 single, 3 stop.
- decim  input  8  decimation: keep 1 of every decim+1 samples.
- rearm  input  1  single-cycle pulse; restarts single mode.
- out_data  output  DN  decimated sample.
- out_valid  output  1  out_data valid this cycle (one-cycle pulse per sample).
- out_sof  output  1  first sample of frame; asserted together with out_valid.
- out_eof  output  1  last sample of frame; asserted together with out_valid.
- armed  output  1  state is WAIT.
- busy  output  1  state is CAPTURE.

Behaviour:
- Reset (async, n_reset=0) forces:
  - all outputs 0;
  - state IDLE;
  - decimation counter dcnt=0, sample count 0, timeout counter 0, edge-armed flag 0.
- Decimator:
  - dcnt counts 0..decim, wrapping to 0.
  - Strobe stb=1 when dcnt==decim; decim=0 gives stb every cycle.
  - On stb, s_reg<=in_data (cycle t).
  - Stage 2 registers the compare result and s_reg, so out_* appear at cycle t+2.
  - Changing decim mid-run: if dcnt>decim, dcnt wraps to 0 on the next cycle with no strobe.
- Edge-armed flag (evaluated on each strobed sample in WAIT):
  - Rising: set when sample < level-HYST; the comparison saturates at 0, so if level<HYST the flag sets when sample==0.
  - Falling: set when sample > level+HYST; saturates at 2^DN-1.
  - The flag is cleared on entry to WAIT.
- Trigger condition: flag set and (rising: sample >= level; falling: sample <= level). Comparisons are unsigned.
- States:
  - IDLE:
    - mode!=3 -> WAIT.
    - mode==3 -> stays in IDLE.
  - WAIT:
    - armed=1.
    - Trigger -> CAPTURE; the triggering sample becomes output sample 0 with out_sof=1.
    - Auto mode: timeout counter increments every clkADC cycle. At TIMEOUT-1 the next strobed sample is force-triggered, even without the flag. The counter clears on entry to WAIT.
    - mode becomes 3 -> IDLE.
  - CAPTURE:
    - busy=1.
    - Each strobed sample produces out_valid=1.
    - Sample index FRAME_LEN-1 carries out_eof=1, then -> DONE.
    - Mode changes are ignored until the frame completes.
  - DONE:
    - Modes 0/1 -> WAIT on the next cycle.
    - Mode 2 waits for rearm=1, then -> WAIT.
    - Mode 3 -> IDLE.
    - rearm is ignored in every other state.
- Frame sizing: exactly FRAME_LEN out_valid pulses per frame, with out_sof on the first and out_eof on the last. No out_valid outside CAPTURE.
- Back-to-back frames: minimum gap from out_eof to the next out_sof is 2 strobes.
- No backpressure: the downstream must accept one sample per strobe.
- Reset asserted mid-frame aborts the frame with no out_eof; after release the block restarts in IDLE.

Test Plan:
- mode=0, decim=0, level=512, slope=0, ramp in_data 0..1023 repeating, FRAME_LEN=16 -> out_sof on out_data=512 exactly 2 cycles after in_data=512; 16 consecutive out_valid carrying 512..527; out_eof on 527.
- decim=3, constant ramp -> out_valid every 4th cycle; out_data steps by 4; dcnt wraps correctly.
- slope=1, level=300, sine crossing 300 downward, noise ±5 with HYST=8 -> exactly one trigger per falling crossing; no retrigger on noise.
- mode=1, in_data held at 100, level=512, TIMEOUT=50 -> forced out_sof at out_data=100 within 50+decim+3 cycles of entering WAIT.
- mode=2 -> one frame then DONE with armed=0; no further out_valid until rearm pulse; rearm issued during CAPTURE is ignored.
- Assert n_reset=0 at sample 5 of a frame -> all outputs 0 immediately; after release, armed=1 one cycle later; the next frame starts with out_sof.
